softplus_sq_pwl_eval: RTL and testbench

Pipelined piecewise-linear evaluator for softplus²(x) in the VAE datapath, Q8.8 signed fixed point. Computes y = slope(x)·x + offset(x). Slope and offset come from external combinational segment lookup tables. The block drives the table index and consumes the returned values. A valid/ready stream handshake is used on both sides, and the whole pipeline stalls together.

---
 rtl/softplus_sq_pwl_eval_if.sv | 40 ++++
 rtl/softplus_sq_pwl_eval.sv | 101 ++++++++++
 tb/tb_softplus_sq_pwl_eval.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/softplus_sq_pwl_eval_if.sv
// Stream and LUT-side signal bundle for softplus_sq_pwl_eval.
// The slave modport is the evaluator's view; master is the surrounding logic.
interface softplus_sq_pwl_eval_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] lut_x;
    logic [15:0] slope_in;
    logic [15:0] offset_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        busy;

    modport slave (
        input  in_valid,
        input  in_x,
        input  slope_in,
        input  offset_in,
        input  out_ready,
        output in_ready,
        output lut_x,
        output out_valid,
        output out_y,
        output busy
    );

    modport master (
        output in_valid,
        output in_x,
        output slope_in,
        output offset_in,
        output out_ready,
        input  in_ready,
        input  lut_x,
        input  out_valid,
        input  out_y,
        input  busy
    );
endinterface

// File: rtl/softplus_sq_pwl_eval.sv
// Three-stage piecewise-linear softplus^2 evaluator, Q8.8: y = clamp(slope(x)*x + offset(x)).
// Slope/offset come from an external combinational LUT indexed by the registered stage-1 operand.
module softplus_sq_pwl_eval #(
    parameter int unsigned    DW      = 16,
    parameter int unsigned    FRAC    = 8,
    parameter logic [DW-1:0]  SAT_MAX = 16'h7FFF
) (
    input logic                   clk,
    input logic                   rst_n,
    softplus_sq_pwl_eval_if.slave bus
);

    logic          en;
    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [DW-1:0] x1_q, x1_d;
    logic [DW-1:0] p2_q, p2_d;
    logic [DW-1:0] o2_q, o2_d;
    logic [DW-1:0] y_q, y_d;

    logic [2*DW-1:0] prod;
    logic [2*DW-1:0] prod_sh;
    logic [DW-1:0]   p_sat;
    logic [DW:0]     sum;
    logic [DW-1:0]   y_clamp;

    // Whole pipeline advances together; only a held output blocks it.
    assign en           = ~v3_q | bus.out_ready;
    assign bus.in_ready = en;
    assign bus.lut_x    = x1_q;
    assign bus.out_valid = v3_q;
    assign bus.out_y    = y_q;
    assign bus.busy     = v1_q | v2_q | v3_q;

    always_comb begin
        prod    = $signed({{DW{x1_q[DW-1]}}, x1_q}) *
                  $signed({{DW{bus.slope_in[DW-1]}}, bus.slope_in});
        prod_sh = $signed(prod) >>> FRAC;
        // In range only if everything above the result sign bit is a copy of it.
        if (prod_sh[2*DW-1:DW-1] == {(DW+1){1'b0}} ||
            prod_sh[2*DW-1:DW-1] == {(DW+1){1'b1}}) begin
            p_sat = prod_sh[DW-1:0];
        end else if (prod_sh[2*DW-1]) begin
            p_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            p_sat = {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_comb begin
        sum = {p2_q[DW-1], p2_q} + {o2_q[DW-1], o2_q};
        if (sum[DW]) begin
            y_clamp = '0;
        end else if (sum[DW-1:0] > SAT_MAX) begin
            y_clamp = SAT_MAX;
        end else begin
            y_clamp = sum[DW-1:0];
        end
    end

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        x1_d = x1_q;
        p2_d = p2_q;
        o2_d = o2_q;
        y_d  = y_q;
        if (en) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                x1_d = bus.in_x;
            end
            v2_d = v1_q;
            p2_d = p_sat;
            o2_d = bus.offset_in;
            v3_d = v2_q;
            y_d  = y_clamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            x1_q <= '0;
            p2_q <= '0;
            o2_q <= '0;
            y_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            x1_q <= x1_d;
            p2_q <= p2_d;
            o2_q <= o2_d;
            y_q  <= y_d;
        end
    end

endmodule

// File: tb/tb_softplus_sq_pwl_eval.sv
// Directed bench for softplus_sq_pwl_eval: fixed-LUT single samples, then streams
// against a behavioural LUT and an integer reference model.
module tb_softplus_sq_pwl_eval;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        use_fn;
    logic [15:0] k_s;
    logic [15:0] k_o;

    softplus_sq_pwl_eval_if bus ();

    softplus_sq_pwl_eval #(
        .DW      (16),
        .FRAC    (8),
        .SAT_MAX (16'h7FFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lut_s(input logic [15:0] x);
        return {{4{x[15]}}, x[15:4]};
    endfunction

    function automatic logic [15:0] lut_o(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    always_comb begin
        if (use_fn) begin
            bus.slope_in  = lut_s(bus.lut_x);
            bus.offset_in = lut_o(bus.lut_x);
        end else begin
            bus.slope_in  = k_s;
            bus.offset_in = k_o;
        end
    end

    function automatic logic [15:0] ref_y(input logic [15:0] x);
        longint prod;
        longint p;
        longint s;
        prod = longint'($signed(x)) * longint'($signed(lut_s(x)));
        p = prod >>> 8;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        s = p + longint'($signed(lut_o(x)));
        if (s < 0) return 16'h0000;
        if (s > 32767) return 16'h7FFF;
        return 16'(s);
    endfunction

    function automatic logic [15:0] stim(input int k);
        return 16'(k * 16'h1357 + 16'hF0A1);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [15:0] x, input logic [15:0] s,
                          input logic [15:0] o, input logic [15:0] exp);
        use_fn       = 1'b0;
        k_s          = s;
        k_o          = o;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        #1;
        chk({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_lut_x"}, bus.lut_x, x);
        chk({tag, "_busy_s1"}, 16'(bus.busy), 16'd1);
        step();
        chk({tag, "_valid_early"}, 16'(bus.out_valid), 16'd0);
        step();
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
        chk({tag, "_y"}, bus.out_y, exp);
        step();
        chk({tag, "_valid_after"}, 16'(bus.out_valid), 16'd0);
        chk({tag, "_busy_after"}, 16'(bus.busy), 16'd0);
    endtask

    task automatic stream(input string tag, input int n, input int seed,
                          input int st, input int sl);
        logic [15:0] exp_q[$];
        logic [15:0] py;
        logic [15:0] plx;
        logic        stalled;
        int sent = 0;
        int got = 0;
        int first_acc = -1;
        int first_out = -1;
        int last_out = -1;
        int drain = 0;
        int i = 0;
        use_fn = 1'b1;
        while (i < 200 && drain < 4) begin
            bus.out_ready = !(i >= st && i < st + sl);
            bus.in_valid  = (sent < n);
            bus.in_x      = stim(sent + seed);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (first_out < 0) first_out = i;
                last_out = i;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL %s_extra: observed output %h expected none", tag, bus.out_y);
                end
                if (exp_q.size() != 0) chk({tag, "_y"}, bus.out_y, exp_q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_y(bus.in_x));
                if (first_acc < 0) first_acc = i;
                sent++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            if (stalled) chk({tag, "_stall_in_ready"}, 16'(bus.in_ready), 16'd0);
            py  = bus.out_y;
            plx = bus.lut_x;
            step();
            if (stalled) begin
                chk({tag, "_stall_y"}, bus.out_y, py);
                chk({tag, "_stall_valid"}, 16'(bus.out_valid), 16'd1);
                chk({tag, "_stall_lut_x"}, bus.lut_x, plx);
            end
            if (sent == n && exp_q.size() == 0) drain++;
            i++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, "_count"}, 16'(got), 16'(n));
        chk({tag, "_latency"}, 16'(first_out - first_acc), 16'd3);
        if (sl == 0) chk({tag, "_rate"}, 16'(last_out - first_out), 16'(n - 1));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        use_fn        = 1'b0;
        k_s           = 16'h0000;
        k_o           = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.in_x      = 16'h0000;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #2;
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_out_y", bus.out_y, 16'h0000);
        chk("rst_lut_x", bus.lut_x, 16'h0000);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
        step();
        rst_n = 1'b1;
        step();

        single("pos", 16'h0200, 16'h0080, 16'h0095, 16'h0195);
        single("neg", 16'hFD00, 16'h0010, 16'h006A, 16'h003A);
        single("neg_clamp0", 16'hFD00, 16'h0010, 16'h0013, 16'h0000);
        single("sat", 16'h7F00, 16'h7FFF, 16'h00E7, 16'h7FFF);

        stream("bp", 6, 0, 5, 4);
        stream("full", 16, 40, 1000, 0);

        // Three samples in flight, output held, then reset mid-cycle.
        use_fn        = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = stim(100 + k);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", 16'(bus.out_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
        chk("mid_rst_busy", 16'(bus.busy), 16'd0);
        chk("mid_rst_y", bus.out_y, 16'h0000);
        chk("mid_rst_lut_x", bus.lut_x, 16'h0000);
        #2;
        rst_n = 1'b1;
        step();
        stream("post_rst", 1, 200, 1000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
